// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order imem requests and buffers returned words.
// Optional FETCH_STATS_EN adds a saturating bubble_cnt output counting empty-head cycles.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] bubble_cnt
`endif
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(BUF_DEPTH);

  logic [31:0]   fetch_pc;
  logic [CW-1:0] occupancy;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_nxt;
  logic [CW-1:0] drop_cnt;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] tag_rd;
  logic [PW-1:0] tag_wr;
  logic [31:0]   buf_pc    [BUF_DEPTH];
  logic [31:0]   buf_instr [BUF_DEPTH];
  logic [31:0]   tag_q     [BUF_DEPTH];

  logic accept;
  logic resp;
  logic resp_drop;
  logic resp_keep;
  logic push;
  logic pop;

  // Credits cover both buffered words and words still in flight, so the FIFO can never overflow.
  assign imem_req  = !reset && !redirect_valid &&
                     (({1'b0, occupancy} + {1'b0, outstanding}) < DEPTH_C);
  assign imem_addr = fetch_pc;

  assign accept    = imem_req && imem_ready;
  assign resp      = imem_rvalid && (outstanding != {CW{1'b0}});
  assign resp_drop = resp && (drop_cnt != {CW{1'b0}});
  assign resp_keep = resp && (drop_cnt == {CW{1'b0}});
  assign push      = resp_keep && !redirect_valid;
  assign pop       = instr_valid && !stall_in && !redirect_valid;

  assign outstanding_nxt = outstanding + CW'(accept) - CW'(resp);

  assign instr_valid = (occupancy != {CW{1'b0}});
  assign pc_out      = instr_valid ? buf_pc[rd_ptr]    : 32'h0000_0000;
  assign instr_out   = instr_valid ? buf_instr[rd_ptr] : 32'h0000_0000;

  // Control state: PC, credit counters, pointers; redirect flushes and converts in-flight work to drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      occupancy   <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      tag_rd      <= '0;
      tag_wr      <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect_valid) begin
        fetch_pc  <= redirect_pc;
        drop_cnt  <= outstanding_nxt;
        occupancy <= '0;
        rd_ptr    <= wr_ptr;
        tag_rd    <= tag_wr;
      end else begin
        if (accept) begin
          fetch_pc <= fetch_pc + 32'd4;
          tag_wr   <= tag_wr + PW'(1);
        end
        if (resp_drop) begin
          drop_cnt <= drop_cnt - CW'(1);
        end
        if (resp_keep) begin
          tag_rd <= tag_rd + PW'(1);
        end
        if (push) begin
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        occupancy <= occupancy + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage for in-flight PC tags and buffered {pc, instr}; contents are qualified by the counters.
  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      tag_q[tag_wr] <= fetch_pc;
    end
    if (!reset && push) begin
      buf_pc[wr_ptr]    <= tag_q[tag_rd];
      buf_instr[wr_ptr] <= imem_rdata;
    end
  end

`ifdef FETCH_STATS_EN
  // Saturating count of cycles with no instruction at the head.
  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt <= 32'h0000_0000;
    end else if (!instr_valid && (bubble_cnt != 32'hFFFF_FFFF)) begin
      bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: queue-based transaction model plus an in-order latency memory model.
module tb_fetch_stage;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, stall_in, redirect_valid, imem_ready, imem_rvalid;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, pc_out, instr_out;
`ifdef FETCH_STATS_EN
  logic [31:0] bubble_cnt;
`endif

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .stall_in(stall_in), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .pc_out(pc_out), .instr_out(instr_out)
`ifdef FETCH_STATS_EN
    , .bubble_cnt(bubble_cnt)
`endif
  );

  typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
  typedef struct { logic [31:0] pc; bit drop; } fl_t;
  typedef struct { logic [31:0] d; int due; } mr_t;

  ent_t        m_fifo[$];
  fl_t         m_infl[$];
  mr_t         memq[$];
  logic [31:0] m_pc = RPC;
  logic [31:0] m_bub = 32'h0;
  int          cyc = 0, last_due = 0, lat_min = 1, lat_max = 1;
  int          vectors = 0, miscompares = 0;

  logic        e_req, e_valid;
  logic [31:0] e_addr, e_pc, e_instr;
  logic [97:0] obs, expv;
  assign obs = {imem_req, imem_addr, instr_valid, pc_out, instr_out};

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Apply one cycle of inputs at the negedge and form the expected outputs from the model.
  task automatic drive(input logic rst, input logic st, input logic rd,
                       input logic [31:0] rp, input logic rdy);
    @(negedge clk);
    reset = rst; stall_in = st; redirect_valid = rd; redirect_pc = rp; imem_ready = rdy;
    if (!rst && memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rvalid = 1'b1; imem_rdata = memq[0].d;
    end else begin
      imem_rvalid = 1'b0; imem_rdata = $urandom;
    end
    e_req   = !rst && !rd && ((m_fifo.size() + m_infl.size()) < DEPTH);
    e_addr  = m_pc;
    e_valid = (m_fifo.size() != 0);
    e_pc    = e_valid ? m_fifo[0].pc  : 32'h0;
    e_instr = e_valid ? m_fifo[0].ins : 32'h0;
    expv    = {e_req, e_addr, e_valid, e_pc, e_instr};
    #1;
  endtask

  // Advance the reference model by one clock using the inputs currently applied.
  task automatic update();
    fl_t f;
    int  due;
    if (reset) begin
      m_fifo.delete(); m_infl.delete(); memq.delete();
      m_pc = RPC; m_bub = 32'h0; last_due = cyc;
    end else begin
      if (!e_valid && m_bub != 32'hFFFF_FFFF) m_bub = m_bub + 32'd1;
      if (e_valid && !stall_in && !redirect_valid) void'(m_fifo.pop_front());
      if (imem_rvalid) begin
        void'(memq.pop_front());
        if (m_infl.size() > 0) begin
          f = m_infl.pop_front();
          if (!f.drop && !redirect_valid) m_fifo.push_back('{f.pc, imem_rdata});
        end
      end
      if (redirect_valid) begin
        m_fifo.delete();
        foreach (m_infl[i]) m_infl[i].drop = 1'b1;
        m_pc = redirect_pc;
      end else if (e_req && imem_ready) begin
        m_infl.push_back('{m_pc, 1'b0});
        due = cyc + $urandom_range(lat_max, lat_min);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        memq.push_back('{word_of(m_pc), due});
        m_pc = m_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      vectors++;
      if (obs !== expv) begin
        miscompares++; $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, obs, expv);
      end
      update();
    end
  endtask

  task automatic test_stream();
    logic [31:0] next_a = RPC;
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      vectors++;
      if (obs !== expv) begin
        miscompares++; $display("FAIL stream cyc=%0d got=%h exp=%h", cyc, obs, expv);
      end
      if (imem_req) begin
        vectors++;
        if (imem_addr !== next_a) begin
          miscompares++; $display("FAIL stream_addr got=%h exp=%h", imem_addr, next_a);
        end
        next_a = next_a + 32'd4;
      end
      update();
    end
  endtask

  task automatic test_stall();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 14; i++) begin
      drive(1'b0, (i < 5), 1'b0, 32'h0, 1'b1);
      vectors++;
      if (obs !== expv) begin
        miscompares++; $display("FAIL stall cyc=%0d got=%h exp=%h", cyc, obs, expv);
      end
      update();
    end
  endtask

  task automatic test_redirect(input logic [31:0] target);
    bit seen = 0;
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b0, (i == 3), target, 1'b1);
      vectors++;
      if (obs !== expv) begin
        miscompares++; $display("FAIL redirect cyc=%0d got=%h exp=%h", cyc, obs, expv);
      end
      if (i > 3 && !seen && instr_valid) begin
        seen = 1;
        vectors++;
        if (pc_out !== target || instr_out !== word_of(target)) begin
          miscompares++;
          $display("FAIL redirect_head got pc=%h ins=%h exp pc=%h ins=%h",
                   pc_out, instr_out, target, word_of(target));
        end
      end
      update();
    end
    vectors++;
    if (!seen) begin
      miscompares++; $display("FAIL redirect_timeout no valid head after redirect to %h", target);
    end
  endtask

  task automatic test_ready_low();
    lat_min = 1; lat_max = 2;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, !(i >= 2 && i < 5));
      vectors++;
      if (obs !== expv) begin
        miscompares++; $display("FAIL ready_low cyc=%0d got=%h exp=%h", cyc, obs, expv);
      end
      update();
    end
  endtask

  task automatic test_midstream_reset();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      update();
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    vectors++;
    if (instr_valid !== 1'b1) begin
      miscompares++; $display("FAIL mid_reset_pre got valid=%b exp=1", instr_valid);
    end
    update();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    vectors++;
    if ({instr_valid, pc_out, instr_out, imem_addr} !== {1'b0, 32'h0, 32'h0, RPC}) begin
      miscompares++;
      $display("FAIL mid_reset got v=%b pc=%h ins=%h addr=%h exp 0/0/0/%h",
               instr_valid, pc_out, instr_out, imem_addr, RPC);
    end
    update();
  endtask

  task automatic test_random();
    logic [31:0] r, tgt;
    lat_min = 1; lat_max = 5;
    for (int i = 0; i < 3000; i++) begin
      r   = $urandom;
      tgt = {r[31:2], 2'b00};
      if (r[0]) tgt = {28'hFFF_FFFF, r[3:2], 2'b00};
      drive(($urandom_range(99) == 0), ($urandom_range(99) < 30),
            ($urandom_range(99) < 5), tgt, ($urandom_range(99) < 70));
      vectors++;
      if (obs !== expv) begin
        miscompares++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, expv);
      end
      update();
    end
  endtask

`ifdef FETCH_STATS_EN
  task automatic test_bubble();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    update();
    lat_min = 4; lat_max = 4;
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      vectors++;
      if (bubble_cnt !== m_bub) begin
        miscompares++; $display("FAIL bubble cyc=%0d got=%0d exp=%0d", cyc, bubble_cnt, m_bub);
      end
      update();
    end
  endtask
`endif

  initial begin
    reset = 1'b1; stall_in = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect(32'h0000_0100);
    test_redirect(32'hFFFF_FFF8);
    test_ready_low();
    test_midstream_reset();
    test_random();
`ifdef FETCH_STATS_EN
    test_bubble();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
